// File: rtl/reg_file.sv
// DEPTH x WIDTH register file: one synchronous write port, two combinational read ports,
// and a per-register written-since-reset valid bit. Define REGFILE_BYPASS_EN for write-through forwarding.
module reg_file #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             write_en,
   input  logic [AW-1:0]    in_addr,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AW-1:0]    out1_addr,
   input  logic [AW-1:0]    out2_addr,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic             out1_valid,
   output logic             out2_valid,
   output logic [DEPTH-1:0] valid_map
);

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] valid;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         // NOTE: the storage array is cleared on reset because reads after reset must return 0,
         // so it cannot be left as an unreset RAM; non-blocking assignments keep all updates on the edge.
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         valid <= '0;
      end else if (write_en) begin
         regs[in_addr]  <= in_data;
         valid[in_addr] <= 1'b1;
      end
   end

   assign valid_map = valid;

`ifdef REGFILE_BYPASS_EN
   logic fwd1, fwd2;

   // A pending write is forwarded to any port reading its address, ahead of the edge.
   always_comb begin
      fwd1       = reset_n && write_en && (out1_addr == in_addr);
      fwd2       = reset_n && write_en && (out2_addr == in_addr);
      out1       = fwd1 ? in_data : regs[out1_addr];
      out2       = fwd2 ? in_data : regs[out2_addr];
      out1_valid = fwd1 | valid[out1_addr];
      out2_valid = fwd2 | valid[out2_addr];
   end
`else
   always_comb begin
      out1       = regs[out1_addr];
      out2       = regs[out2_addr];
      out1_valid = valid[out1_addr];
      out2_valid = valid[out2_addr];
   end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file (8 x 8); expectations are hand-computed per vector.
module tb_reg_file;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       write_en;
   logic [2:0] in_addr, out1_addr, out2_addr;
   logic [7:0] in_data, out1, out2, valid_map;
   logic       out1_valid, out2_valid;

   int total = 0;
   int bad   = 0;

   reg_file #(.WIDTH(8), .DEPTH(8), .AW(3)) dut (
      .clk(clk), .reset_n(reset_n), .write_en(write_en),
      .in_addr(in_addr), .in_data(in_data),
      .out1_addr(out1_addr), .out2_addr(out2_addr),
      .out1(out1), .out2(out2),
      .out1_valid(out1_valid), .out2_valid(out2_valid),
      .valid_map(valid_map)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      write_en = 1'b1;
      in_addr  = a;
      in_data  = d;
      @(posedge clk);
      #1 write_en = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a1, input logic [2:0] a2);
      @(negedge clk);
      out1_addr = a1;
      out2_addr = a2;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b1; write_en = 1'b0; in_addr = '0; in_data = '0;
      out1_addr = '0; out2_addr = '0;

      // Reset state
      do_reset();
      rd(3'd0, 3'd1);
      check("reset_map", valid_map, 8'h00);
      check("reset_out1_valid", out1_valid, 1'b0);

      // Two writes, two ports, shared address
      wr(3'd3, 8'h5A);
      wr(3'd7, 8'hC3);
      rd(3'd3, 3'd7);
      check("wr_out1_r3", out1, 8'h5A);
      check("wr_out2_r7", out2, 8'hC3);
      check("wr_map", valid_map, 8'h88);
      check("wr_v1", out1_valid, 1'b1);
      check("wr_v2", out2_valid, 1'b1);
      rd(3'd7, 3'd7);
      check("same_addr_out1", out1, 8'hC3);
      check("same_addr_out2", out2, 8'hC3);

      // Back-to-back writes, last edge wins
      wr(3'd6, 8'h12);
      wr(3'd6, 8'h34);
      rd(3'd6, 3'd3);
      check("b2b_r6", out1, 8'h34);
      check("b2b_map", valid_map, 8'hC8);

      // Reset after prior writes clears everything
      do_reset();
      for (int i = 0; i < 8; i++) begin
         rd(3'(i), 3'(7 - i));
         check($sformatf("rst_r%0d_p1", i), out1, 8'h00);
         check($sformatf("rst_r%0d_p2", i), out2, 8'h00);
      end
      check("rst_map", valid_map, 8'h00);

      // Same-cycle write and read of one address
      wr(3'd2, 8'h44);
      @(negedge clk);
      write_en = 1'b1; in_addr = 3'd2; in_data = 8'h11;
      out1_addr = 3'd2; out2_addr = 3'd3;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("pre_edge_r2", out1, 8'h11);
`else
      check("pre_edge_r2", out1, 8'h44);
`endif
      check("pre_edge_other", out2, 8'h00);
      check("pre_edge_other_v", out2_valid, 1'b0);
      @(posedge clk);
      #1 write_en = 1'b0;
      check("post_edge_r2", out1, 8'h11);

      // Reset beats a write on the same edge
      wr(3'd5, 8'hAA);
      rd(3'd5, 3'd5);
      check("r5_before", out1, 8'hAA);
      @(negedge clk);
      write_en = 1'b1; in_addr = 3'd5; in_data = 8'hFF; reset_n = 1'b0;
      @(posedge clk);
      #1 write_en = 1'b0; reset_n = 1'b1;
      rd(3'd5, 3'd2);
      check("rst_wins_r5", out1, 8'h00);
      check("rst_wins_v5", valid_map[5], 1'b0);
      check("rst_wins_r2", out2, 8'h00);

      // Writing zero still sets the valid bit
      wr(3'd0, 8'h00);
      rd(3'd0, 3'd1);
      check("zero_out1", out1, 8'h00);
      check("zero_v1", out1_valid, 1'b1);
      check("zero_map", valid_map, 8'h01);

      // write_en low holds state; a mid-cycle reset pulse is not asynchronous
      wr(3'd4, 8'h3C);
      @(negedge clk);
      write_en = 1'b0; in_addr = 3'd4; in_data = 8'h77;
      repeat (3) @(posedge clk);
      rd(3'd4, 3'd0);
      check("hold_r4", out1, 8'h3C);
      check("hold_map", valid_map, 8'h11);
      reset_n = 1'b0;
      #1;
      check("sync_rst_r4", out1, 8'h3C);
      check("sync_rst_map", valid_map, 8'h11);
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("sync_rst_after_edge", out1, 8'h3C);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
